// File: rtl/apb_stream_bridge.sv
// APB3 slave bridging register accesses to a TX/RX pair of valid/ready streams.
// APB writes to TXDATA feed the outbound stream; the inbound stream is read
// back word by word through RXDATA. Optional wait states stretch each access.
module apb_stream_bridge #(
  parameter int DEPTH = 16,
  parameter int DELAY = 0
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic [31:0] PADDR,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        M_VALID,
  input  logic        M_READY,
  output logic [31:0] M_DATA,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic [31:0] S_DATA
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [3:0]    DLY      = 4'(DELAY);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t     state, state_nxt;
  logic [3:0] wcnt, wcnt_nxt;

  logic access, done;
  logic [1:0] reg_sel;
  logic bad_off;
  logic unused_addr;

  logic wr_ok, rd_ok;
  logic wr_tx, wr_rx, wr_stat, wr_ctrl, rd_rx;

  // TX FIFO
  logic [31:0]   tx_mem [DEPTH];
  logic [AW-1:0] tx_wr, tx_rd;
  logic [CW-1:0] tx_cnt;
  logic tx_full, tx_empty, tx_push, tx_pop, tx_flush;

  // RX FIFO
  logic [31:0]   rx_mem [DEPTH];
  logic [AW-1:0] rx_wr, rx_rd;
  logic [CW-1:0] rx_cnt;
  logic rx_full, rx_empty, rx_push, rx_pop, rx_flush;

  // Control and sticky status
  logic tx_en, rx_en;
  logic tx_ovf, rx_unf;
  logic tx_ovf_set, rx_unf_set, tx_ovf_clr, rx_unf_clr;
  logic [31:0] status_word;

  // Access handshake: PREADY is high outside an access and once the wait
  // counter reaches DELAY inside one.
  assign access = PSEL & PENABLE;
  assign PREADY = !access | (wcnt == DLY);
  assign done   = access & PREADY;

  // Address decode: four word registers, anything at or above 0x010 errors.
  assign reg_sel     = PADDR[3:2];
  assign bad_off     = |PADDR[11:4];
  assign unused_addr = ^{PADDR[31:12], PADDR[1:0]};

  assign wr_ok   = done & PWRITE & !bad_off;
  assign rd_ok   = done & !PWRITE & !bad_off;
  assign wr_tx   = wr_ok & (reg_sel == 2'd0);
  assign wr_rx   = wr_ok & (reg_sel == 2'd1);
  assign wr_stat = wr_ok & (reg_sel == 2'd2);
  assign wr_ctrl = wr_ok & (reg_sel == 2'd3);
  assign rd_rx   = rd_ok & (reg_sel == 2'd1);

  // FIFO flags come from the counts as they stand before the edge.
  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);

  assign tx_push  = wr_tx & !tx_full;
  assign tx_pop   = M_VALID & M_READY;
  assign tx_flush = wr_ctrl & PWDATA[2];
  assign rx_push  = S_VALID & S_READY;
  assign rx_pop   = rd_rx & !rx_empty;
  assign rx_flush = wr_ctrl & PWDATA[3];

  assign tx_ovf_set = wr_tx & tx_full;
  assign rx_unf_set = rd_rx & rx_empty;
  assign tx_ovf_clr = wr_stat & PWDATA[4];
  assign rx_unf_clr = wr_stat & PWDATA[5];

  // Streams: TX head falls through; zeroed while empty so reset shows 0.
  assign M_VALID = tx_en & !tx_empty;
  assign M_DATA  = tx_empty ? 32'd0 : tx_mem[tx_rd];
  assign S_READY = rx_en & !rx_full;

  assign status_word = {8'(rx_cnt), 8'(tx_cnt), 10'd0,
                        rx_unf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full};

  // Wait-state FSM and counter registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
      wcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next state: count up while the access is stalled, clear on completion
  // or when the master abandons the access.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    if (!access) begin
      state_nxt = IDLE;
      wcnt_nxt  = 4'd0;
    end else if (PREADY) begin
      state_nxt = IDLE;
      wcnt_nxt  = 4'd0;
    end else begin
      state_nxt = ACCESS;
      wcnt_nxt  = wcnt + 4'd1;
    end
  end

  // Read data and error response, driven only on the completing cycle.
  always_comb begin
    PRDATA  = 32'd0;
    PSLVERR = 1'b0;
    if (done) begin
      if (bad_off) begin
        PSLVERR = 1'b1;
      end else begin
        case (reg_sel)
          2'd0: PSLVERR = PWRITE & tx_full;
          2'd1: begin
            if (PWRITE) begin
              PSLVERR = 1'b1;
            end else begin
              PSLVERR = rx_empty;
              PRDATA  = rx_empty ? 32'd0 : rx_mem[rx_rd];
            end
          end
          2'd2: if (!PWRITE) PRDATA = status_word;
          default: if (!PWRITE) PRDATA = {30'd0, rx_en, tx_en};
        endcase
      end
    end
  end

  // CTRL enables; flush bits are strobes and never stored.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_en <= 1'b0;
      rx_en <= 1'b0;
    end else if (wr_ctrl) begin
      tx_en <= PWDATA[0];
      rx_en <= PWDATA[1];
    end
  end

  // Sticky error bits; a same-cycle set beats a clear.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      tx_ovf <= tx_ovf_set | (tx_ovf & ~tx_ovf_clr);
      rx_unf <= rx_unf_set | (rx_unf & ~rx_unf_clr);
    end
  end

  // TX pointers and count; flush overrides any push or pop.
  always_ff @(posedge PCLK) begin
    if (PRESET || tx_flush) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // TX storage.
  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wr] <= PWDATA;
  end

  // RX pointers and count; flush discards any word arriving that cycle.
  always_ff @(posedge PCLK) begin
    if (PRESET || rx_flush) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // RX storage.
  always_ff @(posedge PCLK) begin
    if (rx_push) rx_mem[rx_wr] <= S_DATA;
  end

endmodule

// File: tb/tb_apb_stream_bridge.sv
// Scoreboard bench for apb_stream_bridge: one zero-wait and one three-wait
// instance, both four entries deep, exercised through directed APB/stream
// sequences with hand-computed expectations.
module tb_apb_stream_bridge;

  localparam int DEPTH = 4;
  localparam logic [31:0] A_TX = 32'h0, A_RX = 32'h4, A_ST = 32'h8, A_CT = 32'hC;

  logic        clk, rst;
  logic        psel0, psel3, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;
  logic        m_ready, s_valid;
  logic [31:0] s_data;
  logic        m_valid0, s_ready0;
  logic [31:0] m_data0;
  logic        m_ready3, s_valid3;
  logic [31:0] s_data3;
  logic        m_valid3, s_ready3;
  logic [31:0] m_data3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } apb_exp_t;

  apb_exp_t    apb_q[$];
  logic [31:0] tx_q[$];
  logic [31:0] tx_exp;
  int tests, fails, last_waits;

  apb_stream_bridge #(.DEPTH(DEPTH), .DELAY(0)) u0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel0), .PADDR(paddr), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0), .M_VALID(m_valid0), .M_READY(m_ready), .M_DATA(m_data0),
    .S_VALID(s_valid), .S_READY(s_ready0), .S_DATA(s_data)
  );

  apb_stream_bridge #(.DEPTH(DEPTH), .DELAY(3)) u3 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel3), .PADDR(paddr), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata3), .PREADY(pready3),
    .PSLVERR(pslverr3), .M_VALID(m_valid3), .M_READY(m_ready3), .M_DATA(m_data3),
    .S_VALID(s_valid3), .S_READY(s_ready3), .S_DATA(s_data3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apb_mon(input logic [31:0] rd, input logic err);
    apb_exp_t e;
    if (apb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL apb_unexpected: got completion rdata 0x%08h err %0b, expected none", rd, err);
    end else begin
      e = apb_q.pop_front();
      check({e.name, "_rdata"}, rd, e.rdata);
      check({e.name, "_err"}, {31'd0, err}, {31'd0, e.err});
    end
  endtask

  // Monitor: compares every APB completion and every TX stream beat.
  always @(negedge clk) begin
    if (psel0 && penable && pready0) apb_mon(prdata0, pslverr0);
    if (psel3 && penable && pready3) apb_mon(prdata3, pslverr3);
    if (m_valid0 && m_ready) begin
      if (tx_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL m_unexpected: got 0x%08h, expected no beat", m_data0);
      end else begin
        tx_exp = tx_q.pop_front();
        check("m_data", m_data0, tx_exp);
      end
    end
  end

  task automatic apb(input bit d3, input string name, input logic [31:0] addr,
                     input bit wr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input bit exp_err);
    apb_exp_t e;
    bit rdy;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.name  = name;
    apb_q.push_back(e);
    @(posedge clk); #1;
    paddr = addr; pwrite = wr; pwdata = wdata; penable = 1'b0;
    if (d3) psel3 = 1'b1; else psel0 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    last_waits = 0;
    while (1) begin
      @(negedge clk);
      rdy = d3 ? pready3 : pready0;
      if (rdy) break;
      last_waits++;
      if (last_waits > 40) begin
        tests++;
        fails++;
        $display("FAIL %s_timeout: got no PREADY in 40 cycles, expected completion", name);
        break;
      end
    end
    @(posedge clk); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  task automatic s_send(input logic [31:0] d);
    int n;
    n = 0;
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = d;
    while (1) begin
      @(negedge clk);
      if (s_ready0) break;
      n++;
      if (n > 40) begin
        tests++;
        fails++;
        $display("FAIL s_send_timeout: got S_READY low 40 cycles, expected high");
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; last_waits = 0;
    rst = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'd0; pwdata = 32'd0; m_ready = 1'b0; s_valid = 1'b0; s_data = 32'd0;
    m_ready3 = 1'b1; s_valid3 = 1'b0; s_data3 = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pready0", {31'd0, pready0}, 32'd1);
    check("rst_pslverr0", {31'd0, pslverr0}, 32'd0);
    check("rst_prdata0", prdata0, 32'd0);
    check("rst_m_valid0", {31'd0, m_valid0}, 32'd0);
    check("rst_s_ready0", {31'd0, s_ready0}, 32'd0);
    check("rst_m_data0", m_data0, 32'd0);
    check("rst_pready3", {31'd0, pready3}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // TX path
    m_ready = 1'b1;
    apb(0, "ctrl_tx_en", A_CT, 1, 32'h1, 32'd0, 0);
    check("wait0", last_waits, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tx_q.push_back(32'hA5A5_0000 + i);
      apb(0, "tx_push", A_TX, 1, 32'hA5A5_0000 + i, 32'd0, 0);
    end
    repeat (4) @(posedge clk);
    apb(0, "stat_tx_done", A_ST, 0, 32'd0, 32'h0000_000A, 0);
    apb(0, "ctrl_rd", A_CT, 0, 32'd0, 32'h1, 0);

    // TX overflow
    apb(0, "ctrl_off", A_CT, 1, 32'h0, 32'd0, 0);
    for (int i = 0; i < DEPTH; i++) apb(0, "tx_fill", A_TX, 1, 32'hB000_0000 + i, 32'd0, 0);
    apb(0, "tx_ovf_push", A_TX, 1, 32'hB000_00FF, 32'd0, 1);
    apb(0, "stat_ovf", A_ST, 0, 32'd0, 32'h0004_0019, 0);
    apb(0, "stat_clr_ovf", A_ST, 1, 32'h10, 32'd0, 0);
    apb(0, "stat_ovf_clr", A_ST, 0, 32'd0, 32'h0004_0009, 0);
    apb(0, "ctrl_tx_flush", A_CT, 1, 32'h4, 32'd0, 0);
    apb(0, "stat_tx_flushed", A_ST, 0, 32'd0, 32'h0000_000A, 0);
    apb(0, "ctrl_flush_rd0", A_CT, 0, 32'd0, 32'h0, 0);
    apb(0, "txdata_rd", A_TX, 0, 32'd0, 32'd0, 0);

    // RX path
    apb(0, "ctrl_rx_en", A_CT, 1, 32'h2, 32'd0, 0);
    s_send(32'h1111);
    s_send(32'h2222);
    apb(0, "rx_pop1", A_RX, 0, 32'd0, 32'h1111, 0);
    apb(0, "rx_pop2", A_RX, 0, 32'd0, 32'h2222, 0);
    apb(0, "rx_unf_rd", A_RX, 0, 32'd0, 32'd0, 1);
    apb(0, "stat_unf", A_ST, 0, 32'd0, 32'h0000_002A, 0);
    apb(0, "stat_clr_unf", A_ST, 1, 32'h20, 32'd0, 0);
    apb(0, "stat_unf_clr", A_ST, 0, 32'd0, 32'h0000_000A, 0);
    apb(0, "rxdata_wr", A_RX, 1, 32'h5555, 32'd0, 1);
    apb(0, "bad_off0", 32'h10, 0, 32'd0, 32'd0, 1);

    // Flush race
    for (int i = 0; i < DEPTH; i++) s_send(32'h3000 + i);
    apb(0, "stat_rx_full", A_ST, 0, 32'd0, 32'h0400_0006, 0);
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 32'hDEAD;
    apb(0, "ctrl_rx_flush", A_CT, 1, 32'hA, 32'd0, 0);
    s_valid = 1'b0;
    apb(0, "stat_rx_flushed", A_ST, 0, 32'd0, 32'h0000_000A, 0);
    apb(0, "ctrl_rx_rd", A_CT, 0, 32'd0, 32'h2, 0);
    apb(0, "rx_after_flush", A_RX, 0, 32'd0, 32'd0, 1);

    // Wait states
    apb(1, "d3_tx_push", A_TX, 1, 32'h77, 32'd0, 0);
    check("d3_wait_push", last_waits, 32'd3);
    apb(1, "d3_stat", A_ST, 0, 32'd0, 32'h0001_0008, 0);
    check("d3_wait_stat", last_waits, 32'd3);
    apb(1, "d3_bad_off", 32'h20, 0, 32'd0, 32'd0, 1);
    check("d3_wait_bad", last_waits, 32'd3);

    // Reset mid-transfer
    @(posedge clk); #1;
    paddr = A_TX; pwrite = 1'b1; pwdata = 32'h99; penable = 1'b0; psel3 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel3 = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("mid_rst_pready3", {31'd0, pready3}, 32'd1);
    check("mid_rst_pslverr3", {31'd0, pslverr3}, 32'd0);
    check("mid_rst_prdata3", prdata3, 32'd0);
    check("mid_rst_m_data3", m_data3, 32'd0);
    check("mid_rst_s_ready0", {31'd0, s_ready0}, 32'd0);
    apb(1, "d3_stat_after_rst", A_ST, 0, 32'd0, 32'h0000_000A, 0);
    apb(0, "stat_after_rst", A_ST, 0, 32'd0, 32'h0000_000A, 0);
    apb(0, "ctrl_after_rst", A_CT, 0, 32'd0, 32'h0, 0);

    repeat (3) @(posedge clk);
    check("apb_q_empty", apb_q.size(), 32'd0);
    check("tx_q_empty", tx_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_stream_bridge.md
# apb_stream_bridge

APB3 slave that bridges the APB bus to a pair of valid/ready streams. It occupies one `PSEL` slot beside the existing memory slaves. APB writes push words into a TX FIFO that drains onto an outbound stream. An inbound stream fills an RX FIFO that APB reads pop. The block is the data-plane responder the APB initiator BFM drives in system benches.

## Interface
Parameters:
- `DEPTH`, 16: entries per FIFO; power of 2, range 2..128.
- `DELAY`, 0: APB wait states inserted per access, range 0..15.

Ports:
- `PCLK`  in  1  clock; all logic on rising edge.
- `PRESET`  in  1  reset; synchronous, active-high.
- `PSEL`  in  1  slave select.
- `PADDR`  in  32  byte address; only `[11:0]` decoded.
- `PENABLE`  in  1  APB access phase.
- `PWRITE`  in  1  1 = write.
- `PWDATA`  in  32  write data.
- `PRDATA`  out  32  read data.
- `PREADY`  out  1  transfer complete.
- `PSLVERR`  out  1  transfer error; qualified by `PREADY`.
- `M_VALID`  out  1  TX stream valid.
- `M_READY`  in  1  TX stream ready.
- `M_DATA`  out  32  TX stream data.
- `S_VALID`  in  1  RX stream valid.
- `S_READY`  out  1  RX stream ready.
- `S_DATA`  in  32  RX stream data.

## Operation
Register map:
- **0x00 TXDATA (W).** A write pushes `PWDATA` into the TX FIFO.
  - TX full: word dropped, `PSLVERR`=1, sticky `tx_ovf` set.
  - A read returns 0 with no error.
- **0x04 RXDATA (R).** A read pops the RX FIFO head.
  - RX empty: `PRDATA`=0, `PSLVERR`=1, sticky `rx_unf` set.
  - A write is ignored with `PSLVERR`=1.
- **0x08 STATUS (R/W1C).**
  - Bit fields: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_ovf, [5] rx_unf.
  - [23:16] tx_cnt and [31:24] rx_cnt, each zero-extended and 0..DEPTH.
  - Writing 1 to [5:4] clears the matching sticky bit; all other bits are read-only.
  - If a set and a clear hit the same cycle, set wins.
- **0x0C CTRL (RW), reset 0.**
  - [0] tx_en, [1] rx_en.
  - [2] tx_flush and [3] rx_flush are self-clearing and always read 0.
- **Any offset ≥ 0x010:** `PSLVERR`=1, `PRDATA`=0, no side effect.

Rules:
- All side effects (push, pop, register write, sticky set/clear, flush) occur only on the completing cycle: `PSEL & PENABLE & PREADY`.
- Streams:
  - `M_VALID` = tx_en & !tx_empty.
  - `M_DATA` = TX head (fall-through).
  - TX pop occurs when `M_VALID & M_READY`.
  - `S_READY` = rx_en & !rx_full; RX push occurs when `S_VALID & S_READY`.
- Simultaneous push and pop on the same FIFO: count unchanged, both take effect. A FIFO full with a concurrent stream pop still rejects the APB push; full is evaluated before the edge.
- Flush has priority over a same-cycle push or pop on that FIFO.
  - Count becomes 0 at the next edge.
  - A TX stream handshake in the flush cycle counts as delivered.
  - An RX stream word in the flush cycle is discarded.
- Pointers wrap modulo `DEPTH`; counts are `log2(DEPTH)+1` bits.

## Timing
- State machine: wait counter with states IDLE and ACCESS.
  - ACCESS is entered on `PSEL & PENABLE`.
  - `PREADY` = (cnt == DELAY). The counter increments while `PREADY`=0 and returns to 0 on completion.
- `DELAY`=0 gives zero-wait APB: two cycles per transfer (setup + access).
- `PRDATA` and `PSLVERR` are combinational, valid only while `PSEL & PENABLE & PREADY`; they are 0 otherwise.
- Stream status is sampled after the edge: a word pushed at edge N is visible on `M_VALID` in cycle N+1. STATUS reflects the state before the completing edge.
- Reset:
  - Takes effect at the first `PCLK` edge with `PRESET`=1, including mid-transfer; any pending transfer is abandoned.
  - Values after reset: FIFOs empty, CTRL=0, sticky bits 0, wait counter 0.
  - Outputs after reset: `PREADY`=1, `PSLVERR`=0, `PRDATA`=0, `M_VALID`=0, `S_READY`=0, `M_DATA`=0 (don't-care while `M_VALID`=0).

## Test plan
- **TX path.** Write CTRL=0x1, then TXDATA 0xA5A5_0001..0xA5A5_0003 with `M_READY`=1 → `M_DATA` emits the three words in order; STATUS[1]=1 afterwards.
- **TX overflow.** Write CTRL=0x0, then write TXDATA `DEPTH`+1 times → last write `PSLVERR`=1; STATUS reads tx_full=1, tx_ovf=1, tx_cnt=`DEPTH`. Write STATUS=0x10 → tx_ovf reads 0.
- **RX path.** Write CTRL=0x2; drive S_DATA 0x1111 then 0x2222 → RXDATA reads return 0x1111, 0x2222. A third read returns 0 with `PSLVERR`=1 and rx_unf=1.
- **Flush race.** Fill RX with 4 words and hold `S_VALID`=1; write CTRL=0xA → next STATUS shows rx_cnt=0.
- **Wait states.** With `DELAY`=3, `PREADY` stays low for exactly 3 access cycles; exactly one push per write, checked via tx_cnt. Bad offset 0x020 → `PSLVERR`=1 after the same delay.
- **Reset mid-transfer.** Assert `PRESET` during a delayed access → all outputs take their reset values at the next edge; a subsequent STATUS read returns 0x0000_000A.
